// File: rtl/step_pulse_gen.sv
// step_pulse_gen: turns a step period, a direction request and a run flag into
// the drv_step/drv_dir pair of a stepper driver. The step-high width is fixed,
// the direction is set up before any step that follows a reversal, and period
// changes take effect only at the next step rise.
// Optional feature: define STEP_POS_EN to build the signed step position counter.
module step_pulse_gen #(
  parameter int WIDTH_WORK = 16,
  parameter int PULSE_W    = 100,
  parameter int DIR_SETUP  = 250,
  parameter int MIN_PERIOD = 400,
  parameter int POS_W      = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH_WORK:0]     period,
  input  logic                    period_valid,
  input  logic                    run,
  input  logic                    dir_req,
  input  logic                    pos_clr,
  output logic                    drv_step,
  output logic                    drv_dir,
  output logic                    step_strobe,
  output logic                    busy,
  output logic signed [POS_W-1:0] pos
);

  localparam int CW = WIDTH_WORK + 1;
  // Counters are loaded with (length - 1) on state entry and the state exits
  // on the edge that sees zero, so each state lasts exactly its length.
  localparam logic [WIDTH_WORK:0] HIGH_RELOAD  = CW'(PULSE_W - 1);
  localparam logic [WIDTH_WORK:0] SETUP_RELOAD = CW'(DIR_SETUP - 1);
  localparam logic [WIDTH_WORK:0] LOW_OFFSET   = CW'(PULSE_W + 1);
  localparam logic [WIDTH_WORK:0] MIN_PER      = CW'(MIN_PERIOD);
  localparam logic [WIDTH_WORK:0] CNT_ONE      = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_DIR_SETUP = 2'd1,
    S_STEP_HIGH = 2'd2,
    S_STEP_LOW  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH_WORK:0] cnt_q, cnt_d;
  logic [WIDTH_WORK:0] per_sh_q, per_sh_d;
  logic [WIDTH_WORK:0] per_act_q, per_act_d;
  logic [WIDTH_WORK:0] per_eff;
  logic                drv_dir_q, drv_dir_d;
  logic                drv_step_q, drv_step_d;
  logic                step_strobe_q, step_strobe_d;
  logic                busy_q, busy_d;
  logic                cnt_zero;
  logic                want_step;
  logic                reversal;

  assign per_eff   = (per_act_q < MIN_PER) ? MIN_PER : per_act_q;
  assign cnt_zero  = (cnt_q == '0);
  assign want_step = run && (per_sh_q != '0);
  assign reversal  = (dir_req != drv_dir_q);

  // Next state, counter reload, direction update, period capture and the
  // output values that the registers will hold after this edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    drv_dir_d = drv_dir_q;
    per_sh_d  = period_valid ? period : per_sh_q;
    per_act_d = per_act_q;

    case (state_q)
      S_IDLE: begin
        if (want_step && reversal) begin
          drv_dir_d = dir_req;
          state_d   = S_DIR_SETUP;
          cnt_d     = SETUP_RELOAD;
        end else if (want_step) begin
          state_d = S_STEP_HIGH;
          cnt_d   = HIGH_RELOAD;
        end
      end
      S_DIR_SETUP: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (run) begin
          state_d = S_STEP_HIGH;
          cnt_d   = HIGH_RELOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_STEP_HIGH: begin
        // run is deliberately ignored here: a started pulse always completes
        if (!cnt_zero) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          state_d = S_STEP_LOW;
          cnt_d   = per_eff - LOW_OFFSET;
        end
      end
      S_STEP_LOW: begin
        // Step boundary: the only place run, period and direction are honoured
        if (!cnt_zero) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (!want_step) begin
          state_d = S_IDLE;
        end else if (reversal) begin
          drv_dir_d = dir_req;
          state_d   = S_DIR_SETUP;
          cnt_d     = SETUP_RELOAD;
        end else begin
          state_d = S_STEP_HIGH;
          cnt_d   = HIGH_RELOAD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The period in force for a step is frozen at its rise; a load on the same
    // edge wins because per_sh_d already carries it.
    if ((state_d == S_STEP_HIGH) && (state_q != S_STEP_HIGH)) begin
      per_act_d = per_sh_d;
    end

    drv_step_d    = (state_d == S_STEP_HIGH);
    step_strobe_d = (state_d == S_STEP_HIGH) && (state_q != S_STEP_HIGH);
    busy_d        = (state_d != S_IDLE);
  end

  // State, counter, period and registered-output flops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      per_sh_q      <= '0;
      per_act_q     <= '0;
      drv_dir_q     <= 1'b0;
      drv_step_q    <= 1'b0;
      step_strobe_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      per_sh_q      <= per_sh_d;
      per_act_q     <= per_act_d;
      drv_dir_q     <= drv_dir_d;
      drv_step_q    <= drv_step_d;
      step_strobe_q <= step_strobe_d;
      busy_q        <= busy_d;
    end
  end

  assign drv_step    = drv_step_q;
  assign drv_dir     = drv_dir_q;
  assign step_strobe = step_strobe_q;
  assign busy        = busy_q;

`ifdef STEP_POS_EN
  logic signed [POS_W-1:0] pos_q, pos_d;

  // Count each emitted step in the direction it was taken; clear has priority
  always_comb begin
    pos_d = pos_q;
    if (pos_clr) begin
      pos_d = '0;
    end else if (step_strobe_q) begin
      pos_d = drv_dir_q ? (pos_q + POS_W'(1)) : (pos_q - POS_W'(1));
    end
  end

  // Position register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos_q <= '0;
    end else begin
      pos_q <= pos_d;
    end
  end

  assign pos = pos_q;
`else
  logic unused_pos_clr;
  assign unused_pos_clr = pos_clr;
  assign pos            = '0;
`endif

endmodule

// File: tb/tb_step_pulse_gen.sv
`timescale 1ns/1ps
module tb_step_pulse_gen;
  localparam int WW  = 16;
  localparam int PWD = WW + 1;
  localparam int PW  = 100;
  localparam int DS  = 250;
  localparam int MP  = 400;
  localparam int PSW = 24;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [WW:0]           period = '0;
  logic                  period_valid = 1'b0;
  logic                  run = 1'b0;
  logic                  dir_req = 1'b0;
  logic                  pos_clr = 1'b0;
  logic                  drv_step, drv_dir, step_strobe, busy;
  logic signed [PSW-1:0] pos;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  step_pulse_gen #(
    .WIDTH_WORK(WW), .PULSE_W(PW), .DIR_SETUP(DS), .MIN_PERIOD(MP), .POS_W(PSW)
  ) dut (
    .clk(clk), .rst(rst), .period(period), .period_valid(period_valid),
    .run(run), .dir_req(dir_req), .pos_clr(pos_clr), .drv_step(drv_step),
    .drv_dir(drv_dir), .step_strobe(step_strobe), .busy(busy), .pos(pos)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- Reference model: timeline of rises and decision points
  int                    me, m_rise, m_decide;
  bit                    m_busy, m_setup, m_strobe, m_dir;
  logic [WW:0]           m_sh, m_act;
  logic signed [PSW-1:0] m_pos;

  task do_rise(input logic [WW:0] sh);
    m_rise   = me;
    m_act    = sh;
    m_decide = me + ((int'(m_act) < MP) ? MP : int'(m_act));
    m_setup  = 1'b0;
    m_busy   = 1'b1;
    m_strobe = 1'b1;
  endtask

  task do_setup();
    m_dir    = dir_req;
    m_setup  = 1'b1;
    m_busy   = 1'b1;
    m_decide = me + DS;
  endtask

  always @(posedge clk or negedge rst) begin
    logic [WW:0] sh_new;
    if (!rst) begin
      me = 0; m_rise = -100000; m_decide = 0;
      m_busy = 0; m_setup = 0; m_strobe = 0; m_dir = 0;
      m_sh = '0; m_act = '0; m_pos = '0;
    end else begin
      me++;
`ifdef STEP_POS_EN
      if (pos_clr) m_pos = '0;
      else if (m_strobe) m_pos = m_dir ? m_pos + PSW'(1) : m_pos - PSW'(1);
`endif
      m_strobe = 1'b0;
      sh_new = period_valid ? period : m_sh;
      if (!m_busy) begin
        if (run && m_sh != '0) begin
          if (dir_req != m_dir) do_setup();
          else do_rise(sh_new);
        end
      end else if (me == m_decide) begin
        if (m_setup) begin
          if (run) do_rise(sh_new);
          else begin m_busy = 1'b0; m_setup = 1'b0; end
        end else if (!run || m_sh == '0) m_busy = 1'b0;
        else if (dir_req != m_dir) do_setup();
        else do_rise(sh_new);
      end
      m_sh = sh_new;
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    logic [PSW+3:0] a, x;
    logic           exp_step;
    if (chk_en) begin
      exp_step = m_busy && !m_setup && ((me - m_rise) < PW);
      a = {drv_step, drv_dir, step_strobe, busy, pos};
      x = {exp_step, m_dir, m_strobe, m_busy, m_pos};
      check("model_outputs", longint'(a), longint'(x));
    end
  end

  // ---------------- Helpers (all waits bounded)
  task automatic load(input int p);
    @(negedge clk); period = PWD'(p); period_valid = 1'b1;
    @(negedge clk); period_valid = 1'b0;
  endtask

  task automatic wait_strobe(input string name, input int budget, output int t);
    bit ok = 1'b0;
    t = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (step_strobe) begin t = cyc; ok = 1'b1; break; end
    end
    if (!ok) check({name, "_timeout"}, 0, 1);
  endtask

  // which: 0 drv_step, 1 drv_dir, 2 busy
  task automatic wait_level(input string name, input int which, input logic val,
                            input int budget, output int t);
    bit   ok = 1'b0;
    logic s;
    t = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      s = (which == 0) ? drv_step : (which == 1) ? drv_dir : busy;
      if (s == val) begin t = cyc; ok = 1'b1; break; end
    end
    if (!ok) check({name, "_timeout"}, 0, 1);
  endtask

  typedef struct {
    int per;
    bit dir;
    int exp_int;
    int exp_high;
    bit exp_dir;
  } vec_t;
  vec_t tbl [6];

  initial begin
    int t0, t1, t2, td, tf, tb, w, nstr;
    tbl[0] = '{800, 1'b0, 800, PW, 1'b0};
    tbl[1] = '{100, 1'b0, 400, PW, 1'b0};
    tbl[2] = '{400, 1'b1, 400, PW, 1'b1};
    tbl[3] = '{401, 1'b1, 401, PW, 1'b1};
    tbl[4] = '{399, 1'b0, 400, PW, 1'b0};
    tbl[5] = '{800, 1'b0, 800, PW, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", longint'({drv_step, drv_dir, step_strobe, busy, pos}), 0);
    rst = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    check("idle_after_reset_busy", busy, 0);

    // Table-driven steady-state behaviour
    foreach (tbl[i]) begin
      load(tbl[i].per);
      dir_req = tbl[i].dir;
      run = 1'b1;
      wait_strobe("tbl_rise0", 5000, t0);
      w = 1;
      for (int k = 0; k < 1000; k++) begin
        @(negedge clk);
        if (drv_step) w++; else break;
      end
      check($sformatf("tbl%0d_high", i), w, tbl[i].exp_high);
      check($sformatf("tbl%0d_dir", i), drv_dir, tbl[i].exp_dir);
      wait_strobe("tbl_rise1", 5000, t1);
      check($sformatf("tbl%0d_interval", i), t1 - t0, tbl[i].exp_int);
    end

    // Reversal mid-period: flip at boundary, rise DIR_SETUP later
    wait_strobe("rev_rise0", 2000, t0);
    repeat (300) @(negedge clk);
    dir_req = 1'b1;
    wait_level("rev_dir", 1, 1'b1, 2000, td);
    check("rev_flip_at_boundary", td - t0, 800);
    wait_strobe("rev_rise1", 2000, t1);
    check("rev_setup", t1 - td, DS);
    check("rev_spacing", t1 - t0, 800 + DS);

    // Clearing run shortly after a rise
    wait_strobe("stop_rise", 2000, t2);
    check("stop_prev_interval", t2 - t1, 800);
    repeat (10) @(negedge clk);
    run = 1'b0;
    wait_level("stop_fall", 0, 1'b0, 2000, tf);
    check("stop_high_width", tf - t2, PW);
    wait_level("stop_busy", 2, 1'b0, 2000, tb);
    check("stop_busy_fall", tb - t2, 800);
    nstr = 0;
    repeat (1000) begin @(negedge clk); if (step_strobe) nstr++; end
    check("stop_no_rises", nstr, 0);

    // Position: 5 steps forward, 2 back
    @(negedge clk); pos_clr = 1'b1;
    @(negedge clk); pos_clr = 1'b0;
    @(negedge clk);
    check("pos_after_clr", pos, 0);
    dir_req = 1'b1;
    run = 1'b1;
    repeat (5) wait_strobe("pos_fwd", 2000, t0);
    dir_req = 1'b0;
    repeat (2) wait_strobe("pos_back", 2000, t0);
    run = 1'b0;
    wait_level("pos_busy", 2, 1'b0, 2000, tb);
`ifdef STEP_POS_EN
    check("pos_net", pos, 3);
`else
    check("pos_tied_zero", pos, 0);
`endif

    // Period load mid-period only affects the following period
    run = 1'b1;
    wait_strobe("load_rise0", 2000, t0);
    repeat (297) @(negedge clk);
    load(39600);
    wait_strobe("load_rise1", 2000, t1);
    check("load_cur_period", t1 - t0, 800);
    wait_strobe("load_rise2", 40000, t2);
    check("load_new_period", t2 - t1, 39600);

    // Asynchronous reset mid-pulse
    repeat (10) @(negedge clk);
    check("high_before_rst", drv_step, 1);
    #2 rst = 1'b0;
    #1 check("rst_async_drop", drv_step, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_after_rst", longint'({drv_step, busy}), 0);

    // Randomised traffic against the model
    load(600);
    run = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      period_valid = 1'b0;
      pos_clr = 1'b0;
      if ($urandom_range(0, 299) == 0) begin
        period = ($urandom_range(0, 9) == 0) ? '0 : PWD'($urandom_range(50, 900));
        period_valid = 1'b1;
      end
      if ($urandom_range(0, 999) == 0) run = ~run;
      if ($urandom_range(0, 599) == 0) dir_req = ~dir_req;
      if ($urandom_range(0, 399) == 0) pos_clr = 1'b1;
    end
    @(negedge clk);
    period_valid = 1'b0;
    pos_clr = 1'b0;
    run = 1'b0;
    wait_level("rand_drain", 2, 1'b0, 5000, tb);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
